jt6295_adpcm_mc: RTL and testbench

Parametrised, time-multiplexed OKI/MSM6295-style 4-bit ADPCM decoder with per-channel state held in internal storage instead of shift registers. It accepts nibbles for any channel in any order through a valid/ready handshake and stalls automatically on same-channel hazards. Each decoded sample is attenuated and emitted, and a scanning accumulator produces a saturated channel mix once per frame. It sits between the sample-fetch engine and the sound output filter.

---
 rtl/jt6295_adpcm_pkg.sv | 43 ++++
 rtl/jt6295_adpcm_dp.sv | 83 ++++++++
 rtl/jt6295_adpcm_mc.sv | 140 ++++++++++++++
 tb/tb_jt6295_adpcm_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_adpcm_pkg.sv
// Shared constants and helpers for the time-multiplexed OKI ADPCM decoder.
package jt6295_adpcm_pkg;

  localparam int unsigned STEP_MAX = 48;

  localparam logic [10:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552
  };

  localparam logic [5:0] GAIN_TBL [16] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
    6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
  };

  localparam logic [3:0] IDX_INC [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047) return 12'sd2047;
    if (v < -14'sd2048) return -12'sd2048;
    return v[11:0];
  endfunction

  // Result is sized for the widest mix; callers truncate to their MW.
  function automatic logic signed [17:0] sat_mw(input logic signed [16:0] v,
                                                input int unsigned mw);
    int hi;
    int lo;
    int x;
    hi = (1 << (mw - 1)) - 1;
    lo = -(1 << (mw - 1));
    x  = int'(v);
    if (x > hi) x = hi;
    else if (x < lo) x = lo;
    return 18'(x);
  endfunction

endpackage

// File: rtl/jt6295_adpcm_dp.sv
// Four-stage ADPCM datapath: channel state and nibble in, new state and scaled sample out.
module jt6295_adpcm_dp
  import jt6295_adpcm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [5:0]         i_idx,
  input  logic signed [11:0] i_pred,
  input  logic [3:0]         i_nib,
  input  logic [3:0]         i_att,
  output logic [5:0]         o_idx,
  output logic signed [11:0] o_pred,
  output logic signed [11:0] o_snd
);

  logic [10:0]        r1_step, r2_step;
  logic [5:0]         r1_idx, r3_idx;
  logic signed [11:0] r1_pred, r2_pred, r3_pred;
  logic [3:0]         r1_nib, r1_att, r2_att, r3_att;
  logic               r2_sgn, r3_sgn;
  logic [1:0]         r2_lo;
  logic [6:0]         w2_idx, r2_idx;
  logic [11:0]        w2_diff, r2_diff, w3_diff, r3_diff;
  logic [5:0]         w3_idx;
  logic signed [13:0] w4_sum;
  logic signed [18:0] w4_prod;

  always_comb begin
    w2_diff = {4'd0, r1_step[10:3]};
    if (r1_nib[2]) w2_diff = w2_diff + {1'b0, r1_step};
    // idx is carried in 7 bits so that 0-1 shows up as a negative value to clamp.
    w2_idx = {1'b0, r1_idx};
    if (r1_nib[2]) w2_idx = w2_idx + {3'b000, IDX_INC[r1_nib[1:0]]};
    else           w2_idx = w2_idx - 7'd1;
  end

  always_comb begin
    w3_diff = r2_diff;
    if (r2_lo[1]) w3_diff = w3_diff + {2'b00, r2_step[10:1]};
    if (r2_lo[0]) w3_diff = w3_diff + {3'b000, r2_step[10:2]};
    if (r2_idx[6])                    w3_idx = 6'd0;
    else if (r2_idx > 7'(STEP_MAX))   w3_idx = 6'(STEP_MAX);
    else                              w3_idx = r2_idx[5:0];
  end

  always_comb begin
    if (r3_sgn) w4_sum = $signed({{2{r3_pred[11]}}, r3_pred} - {2'b00, r3_diff});
    else        w4_sum = $signed({{2{r3_pred[11]}}, r3_pred} + {2'b00, r3_diff});
    o_pred  = sat12(w4_sum);
    o_idx   = r3_idx;
    w4_prod = $signed({{7{o_pred[11]}}, o_pred}) * $signed({13'd0, GAIN_TBL[r3_att]});
    o_snd   = 12'(w4_prod >>> 5);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_step <= '0; r1_idx <= '0; r1_pred <= '0; r1_nib <= '0; r1_att <= '0;
      r2_step <= '0; r2_idx <= '0; r2_pred <= '0; r2_diff <= '0; r2_sgn <= 1'b0;
      r2_lo   <= '0; r2_att <= '0;
      r3_idx  <= '0; r3_pred <= '0; r3_diff <= '0; r3_sgn <= 1'b0; r3_att <= '0;
    end else if (cen) begin
      r1_step <= STEP_TBL[i_idx];
      r1_idx  <= i_idx;
      r1_pred <= i_pred;
      r1_nib  <= i_nib;
      r1_att  <= i_att;
      r2_step <= r1_step;
      r2_idx  <= w2_idx;
      r2_pred <= r1_pred;
      r2_diff <= w2_diff;
      r2_sgn  <= r1_nib[3];
      r2_lo   <= r1_nib[1:0];
      r2_att  <= r1_att;
      r3_idx  <= w3_idx;
      r3_pred <= r2_pred;
      r3_diff <= w3_diff;
      r3_sgn  <= r2_sgn;
      r3_att  <= r2_att;
    end
  end

endmodule

// File: rtl/jt6295_adpcm_mc.sv
// Multi-channel ADPCM decoder: state memory, in-flight tags, hazard stall and frame mixer.
module jt6295_adpcm_mc
  import jt6295_adpcm_pkg::*;
#(
  parameter  int unsigned CH  = 4,
  parameter  int unsigned MW  = 14,
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 nib_valid,
  output logic                 nib_ready,
  input  logic [CHW-1:0]       nib_ch,
  input  logic [3:0]           nib_data,
  input  logic [3:0]           nib_att,
  input  logic                 clr_valid,
  input  logic [CHW-1:0]       clr_ch,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [11:0]   out_snd,
  output logic signed [MW-1:0] mix,
  output logic                 mix_stb
);

  logic [17:0]        r_mem [CH];
  logic signed [11:0] r_last [CH];
  logic               r_v1, r_v2, r_v3;
  logic [CHW-1:0]     r_ch1, r_ch2, r_ch3;
  logic               r_out_valid, r_mix_stb;
  logic [CHW-1:0]     r_out_ch, r_scan;
  logic signed [11:0] r_out_snd;
  logic signed [MW-1:0] r_mix;
  logic signed [16:0] r_acc;

  logic [17:0]        w_rd;
  logic               w_acc, w_clr, w_wb, w_hit;
  logic [5:0]         w_new_idx;
  logic signed [11:0] w_new_pred, w_snd, w_cur;
  logic signed [16:0] w_sum;

  assign w_rd  = r_mem[nib_ch];
  assign w_hit = (r_v1 && r_ch1 == nib_ch) || (r_v2 && r_ch2 == nib_ch) ||
                 (r_v3 && r_ch3 == nib_ch);
  assign nib_ready = ~w_hit;
  assign w_acc = nib_valid & nib_ready & cen;
  assign w_clr = clr_valid & cen;
  // A clear on the same cen cycle suppresses the stage-IV write-back of that channel.
  assign w_wb  = r_v3 & ~(w_clr && clr_ch == r_ch3);

  assign out_valid = r_out_valid & cen;
  assign mix_stb   = r_mix_stb & cen;
  assign out_ch    = r_out_ch;
  assign out_snd   = r_out_snd;
  assign mix       = r_mix;

  jt6295_adpcm_dp u_dp (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .i_idx  (w_rd[17:12]),
    .i_pred (w_rd[11:0]),
    .i_nib  (nib_data),
    .i_att  (nib_att),
    .o_idx  (w_new_idx),
    .o_pred (w_new_pred),
    .o_snd  (w_snd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r_ch1 <= '0;  r_ch2 <= '0;  r_ch3 <= '0;
    end else if (cen) begin
      r_v1  <= w_acc & ~(w_clr && clr_ch == nib_ch);
      r_v2  <= r_v1 & ~(w_clr && clr_ch == r_ch1);
      r_v3  <= r_v2 & ~(w_clr && clr_ch == r_ch2);
      r_ch1 <= nib_ch;
      r_ch2 <= r_ch1;
      r_ch3 <= r_ch2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        r_mem[i]  <= '0;
        r_last[i] <= '0;
      end
    end else if (cen) begin
      for (int i = 0; i < CH; i++) begin
        if (w_clr && clr_ch == CHW'(i)) begin
          r_mem[i]  <= '0;
          r_last[i] <= '0;
        end else if (w_wb && r_ch3 == CHW'(i)) begin
          r_mem[i]  <= {w_new_idx, w_new_pred};
          r_last[i] <= w_snd;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_snd   <= '0;
    end else if (cen) begin
      r_out_valid <= w_wb;
      if (w_wb) begin
        r_out_ch  <= r_ch3;
        r_out_snd <= w_snd;
      end
    end
  end

  assign w_cur = r_last[r_scan];
  assign w_sum = r_acc + {{5{w_cur[11]}}, w_cur};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan    <= '0;
      r_acc     <= '0;
      r_mix     <= '0;
      r_mix_stb <= 1'b0;
    end else if (cen) begin
      if (r_scan == CHW'(CH - 1)) begin
        r_mix     <= MW'(sat_mw(w_sum, MW));
        r_mix_stb <= 1'b1;
        r_acc     <= '0;
        r_scan    <= '0;
      end else begin
        r_acc     <= w_sum;
        r_scan    <= r_scan + 1'b1;
        r_mix_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt6295_adpcm_mc.sv
// Directed bench for jt6295_adpcm_mc with hand-computed ADPCM results.
module tb_jt6295_adpcm_mc;

  logic clk = 1'b0;
  logic rst, cen, nib_valid, clr_valid;
  logic [1:0] nib_ch, clr_ch;
  logic [3:0] nib_data, nib_att;
  logic nib_ready, out_valid, mix_stb;
  logic [1:0] out_ch;
  logic signed [11:0] out_snd;
  logic signed [13:0] mix;
  logic rdy12, ov12, stb12;
  logic [1:0] och12;
  logic signed [11:0] snd12;
  logic signed [11:0] mix12;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int ch; int snd; int cyc; } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  jt6295_adpcm_mc #(.CH(4), .MW(14)) dut (
    .clk(clk), .rst(rst), .cen(cen), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .nib_ch(nib_ch), .nib_data(nib_data), .nib_att(nib_att), .clr_valid(clr_valid),
    .clr_ch(clr_ch), .out_valid(out_valid), .out_ch(out_ch), .out_snd(out_snd),
    .mix(mix), .mix_stb(mix_stb)
  );

  jt6295_adpcm_mc #(.CH(4), .MW(12)) dut12 (
    .clk(clk), .rst(rst), .cen(cen), .nib_valid(nib_valid), .nib_ready(rdy12),
    .nib_ch(nib_ch), .nib_data(nib_data), .nib_att(nib_att), .clr_valid(clr_valid),
    .clr_ch(clr_ch), .out_valid(ov12), .out_ch(och12), .out_snd(snd12),
    .mix(mix12), .mix_stb(stb12)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (out_valid) begin
      e.ch  = int'(out_ch);
      e.snd = int'(out_snd);
      e.cyc = cyc;
      q.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input int d, input int att, output int stalls);
    nib_valid = 1'b1;
    nib_ch    = ch[1:0];
    nib_data  = d[3:0];
    nib_att   = att[3:0];
    stalls    = 0;
    #1;
    while (!nib_ready && stalls < 20) begin
      tick();
      stalls++;
    end
    tick();
    nib_valid = 1'b0;
  endtask

  task automatic get_out(output ev_t e, output int ok);
    int n = 0;
    while (q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    ok = (q.size() != 0) ? 1 : 0;
    if (ok == 1) e = q.pop_front();
    else begin
      e.ch = -1; e.snd = -9999; e.cyc = 0;
    end
  endtask

  task automatic expect_out(input string tag, input int ch, input int snd);
    ev_t e;
    int ok;
    get_out(e, ok);
    chk({tag, "_seen"}, ok, 1);
    chk({tag, "_ch"}, e.ch, ch);
    chk({tag, "_snd"}, e.snd, snd);
  endtask

  task automatic wait_stb(output int at, output int ok);
    int n = 0;
    while (!mix_stb && n < 20) begin
      tick();
      n++;
    end
    ok = mix_stb ? 1 : 0;
    at = cyc;
  endtask

  initial begin
    int st, ok, notrdy, seen, s1, s2;
    int last [4];
    ev_t e, e0;

    rst = 1'b1; cen = 1'b1; nib_valid = 1'b0; clr_valid = 1'b0;
    nib_ch = '0; clr_ch = '0; nib_data = '0; nib_att = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(nib_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_snd", int'(out_snd), 0);
    chk("rst_mix", int'(mix), 0);
    chk("rst_mix_stb", int'(mix_stb), 0);

    // Same-channel back-to-back: second nibble waits for the first write-back.
    send(0, 7, 0, st);
    chk("b_stall1", st, 0);
    send(0, 7, 0, st);
    chk("b_stall2", st, 3);
    expect_out("b_out1", 0, 30);
    chk("b_idx1", int'(dut.r_mem[0][17:12]), 8);
    expect_out("b_out2", 0, 93);
    chk("b_idx2", int'(dut.r_mem[0][17:12]), 16);
    chk("b_pred2", int'($signed(dut.r_mem[0][11:0])), 93);

    send(1, 8, 0, st);
    expect_out("c_neg", 1, -2);
    chk("c_idx", int'(dut.r_mem[1][17:12]), 0);

    for (int i = 0; i < 40; i++) begin
      send(2, 7, 0, st);
      get_out(e, ok);
    end
    chk("d_sat_snd", e.snd, 2047);
    chk("d_sat_idx", int'(dut.r_mem[2][17:12]), 48);
    send(2, 7, 1, st);
    expect_out("d_att1", 2, 1407);
    send(2, 7, 9, st);
    expect_out("d_att9", 2, 0);

    // Clear two cens after acceptance kills the in-flight entry.
    send(3, 7, 0, st);
    tick();
    clr_valid = 1'b1; clr_ch = 2'd3;
    tick();
    clr_valid = 1'b0;
    repeat (8) tick();
    chk("e_no_out", q.size(), 0);
    chk("e_state", int'(dut.r_mem[3]), 0);
    send(3, 7, 0, st);
    expect_out("e_after", 3, 30);

    // Nibble and clear for the same channel on the same cen.
    nib_valid = 1'b1; nib_ch = 2'd1; nib_data = 4'h7; nib_att = 4'd0;
    clr_valid = 1'b1; clr_ch = 2'd1;
    tick();
    nib_valid = 1'b0; clr_valid = 1'b0;
    repeat (8) tick();
    chk("e2_no_out", q.size(), 0);
    chk("e2_state", int'(dut.r_mem[1]), 0);

    // Fresh reset, interleaved ramp of every channel to full scale.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    notrdy = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 4; c++) begin
        nib_valid = 1'b1; nib_ch = 2'(c); nib_data = 4'h7; nib_att = 4'd0;
        #1;
        if (!nib_ready) notrdy++;
        tick();
      end
    end
    nib_valid = 1'b0;
    chk("f_ready", notrdy, 0);
    get_out(e0, ok);
    chk("f_first_ch", e0.ch, 0);
    chk("f_first_snd", e0.snd, 30);
    for (int i = 1; i < 4; i++) begin
      get_out(e, ok);
      chk("f_seq_ch", e.ch, i);
      chk("f_seq_snd", e.snd, 30);
      chk("f_seq_cyc", e.cyc - e0.cyc, i);
    end
    for (int i = 4; i < 40; i++) begin
      get_out(e, ok);
      if (ok == 1 && e.ch >= 0 && e.ch < 4) last[e.ch] = e.snd;
    end
    for (int c = 0; c < 4; c++) chk("f_full", last[c], 2047);

    wait_stb(s1, ok);
    chk("g_stb1", ok, 1);
    tick();
    wait_stb(s2, ok);
    chk("g_stb2", ok, 1);
    chk("g_period", s2 - s1, 4);
    chk("g_mix14", int'(mix), 8188);
    chk("g_mix12", int'(mix12), 2047);

    // With cen low nothing is accepted and no strobe appears.
    cen = 1'b0;
    nib_valid = 1'b1; nib_ch = 2'd0; nib_data = 4'h8; nib_att = 4'd0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || mix_stb) seen++;
    end
    chk("h_no_strobe", seen, 0);
    nib_valid = 1'b0;
    cen = 1'b1;
    repeat (8) tick();
    chk("h_no_accept", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
